dht11_responder: RTL and testbench



---
 rtl/dht11_pkg.sv | 26 ++
 rtl/us_tick.sv | 29 ++
 rtl/dht11_responder.sv | 184 ++++++++++++++++++
 tb/tb_dht11_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared types and helpers for the DHT11 responder: FSM states, frame size
// and the checksum rule.
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOST_LOW,
    WAIT,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } state_t;

  localparam int FRAME_BITS = 40;

  // The 8-bit result width makes the sum wrap modulo 256.
  function automatic logic [7:0] checksum(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] c,
                                          input logic [7:0] d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/us_tick.sv
// Free-running microsecond tick: one-cycle pulse every CLK_HZ/1_000_000 clocks.
module us_tick #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with the handshake and a
// 40-bit humidity/temperature frame. The pin tristate lives one level up.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int T_START_MIN_US = 18000,
  parameter int T_WAIT_US      = 30,
  parameter int T_RESP_US      = 80,
  parameter int T_BIT_LOW_US   = 50,
  parameter int T_ZERO_HIGH_US = 26,
  parameter int T_ONE_HIGH_US  = 70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dht_in,
  output logic       dht_oe,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       corrupt,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [15:0] START_MIN  = 16'(T_START_MIN_US);
  localparam logic [15:0] L_WAIT     = 16'(T_WAIT_US - 1);
  localparam logic [15:0] L_RESP     = 16'(T_RESP_US - 1);
  localparam logic [15:0] L_BIT_LOW  = 16'(T_BIT_LOW_US - 1);
  localparam logic [15:0] L_ZERO     = 16'(T_ZERO_HIGH_US - 1);
  localparam logic [15:0] L_ONE      = 16'(T_ONE_HIGH_US - 1);
  localparam logic [5:0]  LAST_BIT   = 6'(FRAME_BITS - 1);

  logic                  tick;
  logic                  sync_q;
  logic                  line;
  logic                  oe_q1;
  logic                  oe_q2;
  logic                  collision;
  state_t                state;
  logic [15:0]           cnt;
  logic [5:0]            bit_cnt;
  logic [FRAME_BITS-1:0] sr;
  logic [15:0]           hi_last;

  us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Our own low drive reaches 'line' two clocks late; oe_q1/oe_q2 track that
  // echo so a just-released line is not mistaken for a host collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b1;
      line   <= 1'b1;
      oe_q1  <= 1'b0;
      oe_q2  <= 1'b0;
    end else begin
      sync_q <= dht_in;
      line   <= sync_q;
      oe_q1  <= dht_oe;
      oe_q2  <= oe_q1;
    end
  end

  assign collision = !line && !oe_q1 && !oe_q2;
  assign hi_last   = sr[FRAME_BITS-1] ? L_ONE : L_ZERO;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      dht_oe     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // NOTE: the last non-blocking assignment in a block wins, so the
      // cnt <= '0 on every state change below overrides this default count.
      if (tick && cnt != 16'hFFFF) cnt <= cnt + 16'd1;

      case (state)
        IDLE: begin
          if (collision) begin
            state <= HOST_LOW;
            cnt   <= '0;
          end
        end

        HOST_LOW: begin
          if (line) begin
            cnt <= '0;
            if (cnt >= START_MIN) begin
              sr      <= {hum_int, hum_dec, temp_int, temp_dec,
                          checksum(hum_int, hum_dec, temp_int, temp_dec) ^ {8{corrupt}}};
              bit_cnt <= '0;
              busy    <= 1'b1;
              state   <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end

        WAIT: begin
          if (collision) begin
            state <= HOST_LOW;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (tick && cnt >= L_WAIT) begin
            state  <= RESP_LOW;
            dht_oe <= 1'b1;
            cnt    <= '0;
          end
        end

        RESP_LOW: begin
          if (tick && cnt >= L_RESP) begin
            state  <= RESP_HIGH;
            dht_oe <= 1'b0;
            cnt    <= '0;
          end
        end

        RESP_HIGH: begin
          if (collision) begin
            state <= HOST_LOW;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (tick && cnt >= L_RESP) begin
            state  <= BIT_LOW;
            dht_oe <= 1'b1;
            cnt    <= '0;
          end
        end

        BIT_LOW: begin
          if (tick && cnt >= L_BIT_LOW) begin
            state  <= BIT_HIGH;
            dht_oe <= 1'b0;
            cnt    <= '0;
          end
        end

        BIT_HIGH: begin
          if (collision) begin
            state <= HOST_LOW;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (tick && cnt >= hi_last) begin
            sr      <= {sr[FRAME_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 6'd1;
            dht_oe  <= 1'b1;
            cnt     <= '0;
            state   <= (bit_cnt == LAST_BIT) ? END_LOW : BIT_LOW;
          end
        end

        END_LOW: begin
          if (tick && cnt >= L_BIT_LOW) begin
            state      <= IDLE;
            dht_oe     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            cnt        <= '0;
          end
        end

        default: begin
          state  <= IDLE;
          dht_oe <= 1'b0;
          busy   <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: a host model drives the shared wire, and the
// expected per-cycle dht_oe/busy/frame_done trace is built from phase durations.
`timescale 1ns/1ps
module tb_dht11_responder;

  localparam int CLK_HZ   = 1_000_000;
  localparam int T_START  = 100;
  localparam int T_WAIT   = 30;
  localparam int T_RESP   = 80;
  localparam int T_BITLO  = 50;
  localparam int T_ZERO   = 26;
  localparam int T_ONE    = 70;
  // Release-to-busy delay: two synchronizer flops plus the registered decision.
  localparam int SYNC_LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_low = 1'b0;
  logic       corrupt = 1'b0;
  logic [7:0] hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
  logic       dht_in, dht_oe, busy, frame_done;

  // Open-drain wire: low if either end pulls it down.
  assign dht_in = host_low ? 1'b0 : ~dht_oe;

  always #5 clk = ~clk;

  dht11_responder #(
    .CLK_HZ         (CLK_HZ),
    .T_START_MIN_US (T_START)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dht_in     (dht_in),
    .dht_oe     (dht_oe),
    .hum_int    (hum_int),
    .hum_dec    (hum_dec),
    .temp_int   (temp_int),
    .temp_dec   (temp_dec),
    .corrupt    (corrupt),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic oe;
    logic busy;
    logic fd;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          frames_seen = 0;
  int          frames_exp = 0;
  bit          cmp_en = 1'b0;
  logic [39:0] exp_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] frame_word(input int a, input int b, input int c,
                                             input int d, input bit cor);
    int sum;
    sum = (a + b + c + d) % 256;
    if (cor) sum = 255 - sum;
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(sum)};
  endfunction

  task automatic push(input bit oe, input bit b, input bit fd, input int n);
    exp_t e;
    e.oe = oe; e.busy = b; e.fd = fd;
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic build_trace(input logic [39:0] w);
    push(0, 0, 0, SYNC_LAT);
    push(0, 1, 0, T_WAIT);
    push(1, 1, 0, T_RESP);
    push(0, 1, 0, T_RESP);
    for (int i = 39; i >= 0; i--) begin
      push(1, 1, 0, T_BITLO);
      push(0, 1, 0, w[i] ? T_ONE : T_ZERO);
    end
    push(1, 1, 0, T_BITLO);
    push(0, 0, 1, 1);
  endtask

  task automatic truncate(input int keep);
    while (exp_q.size() > keep) void'(exp_q.pop_back());
  endtask

  task automatic host_start(input int hold);
    @(posedge clk); #1 host_low = 1'b1;
    repeat (hold) @(posedge clk);
    #1 host_low = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 10000;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("drain_timeout", budget > 0, 1);
  endtask

  task automatic wait_oe_falls(input int n);
    int   seen, budget;
    logic p;
    seen = 0; budget = 20000; p = dht_oe;
    while (seen < n && budget > 0) begin
      @(posedge clk); #1;
      if (p && !dht_oe) seen++;
      p = dht_oe;
      budget--;
    end
    check("oe_fall_wait", seen, n);
  endtask

  task automatic set_data(input int a, input int b, input int c, input int d, input bit cor);
    hum_int = 8'(a); hum_dec = 8'(b); temp_int = 8'(c); temp_dec = 8'(d); corrupt = cor;
    exp_word = frame_word(a, b, c, d, cor);
  endtask

  task automatic run_frame(input int hold, input bit scramble);
    host_start(hold);
    build_trace(exp_word);
    frames_exp++;
    if (scramble) begin
      repeat (10) @(posedge clk);
      #1;
      hum_int = 8'($urandom); hum_dec = 8'($urandom);
      temp_int = 8'($urandom); temp_dec = 8'($urandom);
      corrupt = 1'($urandom);
    end
    drain();
    repeat (5) @(posedge clk);
  endtask

  // Per-cycle compare against the expected trace; an empty queue means idle.
  always @(negedge clk) begin
    exp_t e;
    if (cmp_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '0;
      check("dht_oe", dht_oe, e.oe);
      check("busy", busy, e.busy);
      check("frame_done", frame_done, e.fd);
    end
  end

  // Independent host-side decoder: classifies released-high widths as bits.
  int          run_len = 0;
  int          nbits = 0;
  logic        prev_oe = 1'b0;
  logic        resp_seen = 1'b0;
  logic [39:0] dec = '0;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (frame_done) begin
        frames_seen++;
        check("decoded_word", dec, exp_word);
        check("decoded_bits", nbits, 40);
      end
      if (!busy) begin
        run_len = 0; nbits = 0; dec = '0; resp_seen = 1'b0; prev_oe = 1'b0;
      end else if (dht_oe != prev_oe) begin
        if (prev_oe && run_len >= 75) resp_seen = 1'b1;
        if (!prev_oe && resp_seen && run_len < 75) begin
          dec = {dec[38:0], run_len > 48};
          nbits++;
        end
        run_len = 1;
        prev_oe = dht_oe;
      end else begin
        run_len++;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1 cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // Model pins from hand arithmetic.
    check("model_basic", frame_word(45, 0, 23, 0, 0), 40'h2D00170044);
    check("model_wrap", frame_word(255, 255, 255, 255, 0), 40'hFFFFFFFFFC);
    check("model_corrupt", frame_word(45, 0, 23, 0, 1), 40'h2D001700BB);

    // Basic frame, then short pulse, wraparound checksum, corrupted checksum.
    set_data(45, 0, 23, 0, 0);
    run_frame(120, 0);
    host_start(60);
    repeat (30) @(posedge clk);
    set_data(255, 255, 255, 255, 0);
    run_frame(120, 0);
    set_data(45, 0, 23, 0, 1);
    run_frame(120, 1);

    // Reset during bit 17, then a clean frame.
    set_data(45, 0, 23, 0, 0);
    host_start(120);
    build_trace(exp_word);
    wait_oe_falls(19);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    truncate(1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    run_frame(120, 0);

    // Host collision during the high phase of bit 5, then a new start.
    host_start(120);
    build_trace(exp_word);
    wait_oe_falls(7);
    repeat (4) @(posedge clk);
    #1 host_low = 1'b1;
    truncate(3);
    repeat (120) @(posedge clk);
    #1 host_low = 1'b0;
    build_trace(exp_word);
    frames_exp++;
    drain();
    repeat (5) @(posedge clk);

    // Random frames with mid-frame data changes, and random short pulses.
    for (int k = 0; k < 5; k++) begin
      set_data(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               1'($urandom));
      run_frame(int'($urandom_range(110, 300)), 1);
      host_start(int'($urandom_range(5, 90)));
      repeat (20) @(posedge clk);
    end

    check("frame_count", frames_seen, frames_exp);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
